// File: rtl/usb_pad_drive_ctrl_if.sv
// ============================================================================
// Module : usb_pad_drive_ctrl_if
// Brief  : Serializer <-> pad-drive sequencer signal bundle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface usb_pad_drive_ctrl_if #(
    parameter int NUM_GROUPS = 4
);
    logic                  tx_req;
    logic                  tx_done;
    logic                  rx_active;
    logic                  tx_gnt;
    logic [NUM_GROUPS-1:0] grp_oe;
    logic                  busy;
    logic                  timeout_err;

    modport master (
        output tx_req, tx_done, rx_active,
        input  tx_gnt, grp_oe, busy, timeout_err
    );

    modport slave (
        input  tx_req, tx_done, rx_active,
        output tx_gnt, grp_oe, busy, timeout_err
    );
endinterface

`default_nettype wire

// File: rtl/usb_pad_drive_ctrl.sv
// ============================================================================
// Module : usb_pad_drive_ctrl
// Brief  : Staggered output-enable sequencer for USB pad driver groups with
//          bus turnaround. Optional drive timeout: USB_PAD_DRIVE_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_pad_drive_ctrl #(
    parameter int NUM_GROUPS       = 4,
    parameter int STAGE_CYCLES     = 2,
    parameter int TURN_CYCLES      = 4,
    parameter int MAX_DRIVE_CYCLES = 1024
) (
    input  wire logic             clk,
    input  wire logic             rst,
    usb_pad_drive_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_DRIVE     = 3'd2,
        S_RAMP_DOWN = 3'd3,
        S_TURN      = 3'd4
    } state_t;

    localparam int c_CNT_MAX = (STAGE_CYCLES > TURN_CYCLES) ? STAGE_CYCLES : TURN_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0]    c_STAGE_LAST = c_CNT_W'(STAGE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]    c_TURN_LAST  = c_CNT_W'(TURN_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]    c_CNT_SAT    = c_CNT_W'(c_CNT_MAX);
    localparam logic [NUM_GROUPS-1:0] c_GRP_ONE    = NUM_GROUPS'(1);

    if (NUM_GROUPS < 1 || STAGE_CYCLES < 1 || TURN_CYCLES < 1 || MAX_DRIVE_CYCLES < 1) begin : g_param_check
        $error("usb_pad_drive_ctrl: all parameters must be >= 1");
    end

    state_t                r_state;
    logic [NUM_GROUPS-1:0] r_grp;
    logic                  r_gnt;
    logic                  r_busy;
    logic                  r_timeout;
    logic [c_CNT_W-1:0]    r_cnt;

    state_t                w_state_nxt;
    logic [NUM_GROUPS-1:0] w_grp_nxt;
    logic                  w_gnt_nxt;
    logic                  w_timeout_nxt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic                  w_timeout;

    // Thermometer shifts: one more group on / the highest group off.
    logic [NUM_GROUPS-1:0] w_grp_up;
    logic [NUM_GROUPS-1:0] w_grp_dn;
    logic                  w_stage_hit;
    logic                  w_can_accept;

    assign w_grp_up     = (r_grp << 1) | c_GRP_ONE;
    assign w_grp_dn     = r_grp >> 1;
    assign w_stage_hit  = (r_cnt == c_STAGE_LAST);
    assign w_can_accept = bus.tx_req && !bus.rx_active;

`ifdef USB_PAD_DRIVE_TIMEOUT_EN
    localparam int c_DCNT_W = $clog2(MAX_DRIVE_CYCLES + 1);

    logic [c_DCNT_W-1:0] r_dcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dcnt <= '0;
        end else if (r_state == S_DRIVE && w_state_nxt == S_DRIVE) begin
            r_dcnt <= r_dcnt + c_DCNT_W'(1);
        end else begin
            r_dcnt <= '0;
        end
    end

    assign w_timeout = (r_state == S_DRIVE) && (r_dcnt == c_DCNT_W'(MAX_DRIVE_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_grp_nxt     = r_grp;
        w_gnt_nxt     = r_gnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_can_accept) begin
                    w_state_nxt = S_RAMP_UP;
                    w_grp_nxt   = c_GRP_ONE;
                end
            end
            S_RAMP_UP: begin
                // An abandoned request wins over the next stagger step.
                if (!bus.tx_req) begin
                    w_grp_nxt   = w_grp_dn;
                    w_state_nxt = (w_grp_dn == '0) ? S_TURN : S_RAMP_DOWN;
                end else if (w_stage_hit) begin
                    if (r_grp[NUM_GROUPS-1]) begin
                        w_state_nxt = S_DRIVE;
                        w_gnt_nxt   = 1'b1;
                    end else begin
                        w_grp_nxt   = w_grp_up;
                    end
                end
            end
            S_DRIVE: begin
                if (bus.tx_done || w_timeout) begin
                    w_gnt_nxt     = 1'b0;
                    w_grp_nxt     = w_grp_dn;
                    w_state_nxt   = (w_grp_dn == '0) ? S_TURN : S_RAMP_DOWN;
                    w_timeout_nxt = !bus.tx_done;
                end
            end
            S_RAMP_DOWN: begin
                if (w_stage_hit) begin
                    w_grp_nxt   = w_grp_dn;
                    w_state_nxt = (w_grp_dn == '0) ? S_TURN : S_RAMP_DOWN;
                end
            end
            S_TURN: begin
                w_grp_nxt = '0;
                w_gnt_nxt = 1'b0;
                // Turnaround expiry doubles as the first IDLE acceptance edge.
                if (r_cnt == c_TURN_LAST) begin
                    if (w_can_accept) begin
                        w_state_nxt = S_RAMP_UP;
                        w_grp_nxt   = c_GRP_ONE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grp_nxt   = '0;
                w_gnt_nxt   = 1'b0;
            end
        endcase

        if (w_state_nxt != r_state || w_grp_nxt != r_grp) begin
            w_cnt_nxt = '0;
        end else if (r_cnt != c_CNT_SAT) begin
            w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_grp     <= '0;
            r_gnt     <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_grp     <= w_grp_nxt;
            r_gnt     <= w_gnt_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_timeout <= w_timeout_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign bus.tx_gnt      = r_gnt;
    assign bus.grp_oe      = r_grp;
    assign bus.busy        = r_busy;
    assign bus.timeout_err = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_usb_pad_drive_ctrl.sv
// ============================================================================
// Module : tb_usb_pad_drive_ctrl
// Brief  : Directed self-checking bench for usb_pad_drive_ctrl.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb_pad_drive_ctrl;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_err = 0;
    int   n_chk = 0;

    always #5 clk = ~clk;

    usb_pad_drive_ctrl_if #(.NUM_GROUPS(N)) bus ();

    usb_pad_drive_ctrl #(
        .NUM_GROUPS       (N),
        .STAGE_CYCLES     (2),
        .TURN_CYCLES      (4),
        .MAX_DRIVE_CYCLES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.tx_req    = 1'b0;
        bus.tx_done   = 1'b0;
        bus.rx_active = 1'b0;
        step();
        step();
        n_chk++; if (bus.grp_oe !== 4'b0000) begin n_err++; $display("FAIL reset_grp got=%b exp=0000", bus.grp_oe); end
        n_chk++; if (bus.tx_gnt !== 1'b0) begin n_err++; $display("FAIL reset_gnt got=%b exp=0", bus.tx_gnt); end
        n_chk++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_chk++; if (bus.timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_to got=%b exp=0", bus.timeout_err); end
        rst = 1'b0;
        step();
        n_chk++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy got=%b exp=0", bus.busy); end
    endtask

    // Leaves the DUT in DRIVE, one cycle after the grant edge (edge 8).
    task automatic test_ramp_up();
        logic [3:0] exp_grp [9];
        exp_grp = '{4'h1, 4'h1, 4'h3, 4'h3, 4'h7, 4'h7, 4'hF, 4'hF, 4'hF};
        bus.tx_req = 1'b1;
        for (int e = 0; e <= 8; e++) begin
            step();
            n_chk++; if (bus.grp_oe !== exp_grp[e]) begin n_err++; $display("FAIL ramp_up_grp e=%0d got=%b exp=%b", e, bus.grp_oe, exp_grp[e]); end
            n_chk++; if (bus.tx_gnt !== (e == 8)) begin n_err++; $display("FAIL ramp_up_gnt e=%0d got=%b exp=%b", e, bus.tx_gnt, (e == 8)); end
            n_chk++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL ramp_up_busy e=%0d got=%b exp=1", e, bus.busy); end
        end
    endtask

    task automatic test_ramp_down();
        logic [3:0] exp_grp [11];
        exp_grp = '{4'h7, 4'h7, 4'h3, 4'h3, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
        step();
        step();
        n_chk++; if (bus.tx_gnt !== 1'b1 || bus.grp_oe !== 4'hF) begin n_err++; $display("FAIL drive_hold got=%b/%b exp=1/1111", bus.tx_gnt, bus.grp_oe); end
        bus.tx_done = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            step();
            bus.tx_done = 1'b0;
            n_chk++; if (bus.grp_oe !== exp_grp[k]) begin n_err++; $display("FAIL ramp_down_grp T+%0d got=%b exp=%b", k, bus.grp_oe, exp_grp[k]); end
            n_chk++; if (bus.tx_gnt !== 1'b0) begin n_err++; $display("FAIL ramp_down_gnt T+%0d got=%b exp=0", k, bus.tx_gnt); end
            n_chk++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL ramp_down_busy T+%0d got=%b exp=1", k, bus.busy); end
        end
        // Abandon the re-accepted request from bit 0 only: straight into TURN.
        bus.tx_req = 1'b0;
        step();
        n_chk++; if (bus.grp_oe !== 4'h0 || bus.busy !== 1'b1) begin n_err++; $display("FAIL abort_bit0 got=%b/%b exp=0000/1", bus.grp_oe, bus.busy); end
        repeat (3) step();
        n_chk++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL turn_busy got=%b exp=1", bus.busy); end
        step();
        n_chk++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL turn_end_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_rx_block();
        bus.rx_active = 1'b1;
        bus.tx_req    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            n_chk++; if ({bus.busy, bus.grp_oe} !== 5'b0) begin n_err++; $display("FAIL rx_block c=%0d got=%b/%b exp=0/0000", i, bus.busy, bus.grp_oe); end
        end
        bus.rx_active = 1'b0;
        step();
        n_chk++; if (bus.grp_oe !== 4'h1 || bus.busy !== 1'b1) begin n_err++; $display("FAIL rx_release got=%b/%b exp=0001/1", bus.grp_oe, bus.busy); end
        bus.tx_req = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_abort();
        logic [3:0] exp_grp [10];
        exp_grp = '{4'h1, 4'h1, 4'h3, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        bus.tx_req = 1'b1;
        for (int e = 0; e <= 9; e++) begin
            step();
            if (e == 2) bus.tx_req = 1'b0;
            n_chk++; if (bus.grp_oe !== exp_grp[e]) begin n_err++; $display("FAIL abort_grp e=%0d got=%b exp=%b", e, bus.grp_oe, exp_grp[e]); end
            n_chk++; if (bus.tx_gnt !== 1'b0) begin n_err++; $display("FAIL abort_gnt e=%0d got=%b exp=0", e, bus.tx_gnt); end
            n_chk++; if (bus.busy !== (e != 9)) begin n_err++; $display("FAIL abort_busy e=%0d got=%b exp=%b", e, bus.busy, (e != 9)); end
        end
    endtask

    task automatic test_reset_mid();
        bus.tx_req = 1'b1;
        repeat (9) step();
        n_chk++; if (bus.tx_gnt !== 1'b1) begin n_err++; $display("FAIL rstmid_gnt got=%b exp=1", bus.tx_gnt); end
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        n_chk++; if (bus.grp_oe !== 4'h7) begin n_err++; $display("FAIL rstmid_pre got=%b exp=0111", bus.grp_oe); end
        #2;
        rst = 1'b1;
        #1;
        n_chk++; if ({bus.tx_gnt, bus.busy, bus.timeout_err, bus.grp_oe} !== 7'b0) begin n_err++; $display("FAIL rstmid_async got=%b%b%b/%b exp=000/0000", bus.tx_gnt, bus.busy, bus.timeout_err, bus.grp_oe); end
        bus.tx_req = 1'b0;
        step();
        rst = 1'b0;
        step();
        n_chk++; if (bus.busy !== 1'b0 || bus.grp_oe !== 4'h0) begin n_err++; $display("FAIL rstmid_idle got=%b/%b exp=0/0000", bus.busy, bus.grp_oe); end
        bus.tx_req = 1'b1;
        step();
        n_chk++; if (bus.grp_oe !== 4'h1) begin n_err++; $display("FAIL rstmid_accept got=%b exp=0001", bus.grp_oe); end
        bus.tx_req = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_timeout();
        bus.tx_req = 1'b1;
        repeat (9) step();
        bus.tx_req = 1'b0;
        n_chk++; if (bus.tx_gnt !== 1'b1) begin n_err++; $display("FAIL to_entry_gnt got=%b exp=1", bus.tx_gnt); end
`ifdef USB_PAD_DRIVE_TIMEOUT_EN
        for (int k = 1; k <= 15; k++) begin
            step();
            n_chk++; if (bus.timeout_err !== 1'b0 || bus.tx_gnt !== 1'b1) begin n_err++; $display("FAIL to_early D+%0d got=%b/%b exp=0/1", k, bus.timeout_err, bus.tx_gnt); end
        end
        step();
        n_chk++; if (bus.timeout_err !== 1'b1 || bus.tx_gnt !== 1'b0 || bus.grp_oe !== 4'h7) begin n_err++; $display("FAIL to_fire got=%b/%b/%b exp=1/0/0111", bus.timeout_err, bus.tx_gnt, bus.grp_oe); end
        step();
        n_chk++; if (bus.timeout_err !== 1'b0) begin n_err++; $display("FAIL to_pulse got=%b exp=0", bus.timeout_err); end
        step();
        n_chk++; if (bus.grp_oe !== 4'h3) begin n_err++; $display("FAIL to_down2 got=%b exp=0011", bus.grp_oe); end
        repeat (2) step();
        n_chk++; if (bus.grp_oe !== 4'h1) begin n_err++; $display("FAIL to_down4 got=%b exp=0001", bus.grp_oe); end
        repeat (2) step();
        n_chk++; if (bus.grp_oe !== 4'h0 || bus.busy !== 1'b1) begin n_err++; $display("FAIL to_turn got=%b/%b exp=0000/1", bus.grp_oe, bus.busy); end
        repeat (4) step();
`else
        for (int k = 1; k <= 110; k++) begin
            step();
            n_chk++; if (bus.tx_gnt !== 1'b1 || bus.timeout_err !== 1'b0) begin n_err++; $display("FAIL no_to_hold D+%0d got=%b/%b exp=1/0", k, bus.tx_gnt, bus.timeout_err); end
        end
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        repeat (10) step();
`endif
        n_chk++; if (bus.busy !== 1'b0 || bus.grp_oe !== 4'h0) begin n_err++; $display("FAIL to_idle got=%b/%b exp=0/0000", bus.busy, bus.grp_oe); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_rx_block();
        test_abort();
        test_reset_mid();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
